// File: rtl/move_sequencer.sv
// move_sequencer: replays a solved move list over a valid/ready handshake under button control.
// Define MOVE_SEQUENCER_REVERSE_EN to enable btn[1] step-back (issues the inverse of the previous move).
module move_sequencer #(
  parameter int TICK_W     = 12,
  parameter int STEP_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        comp,
  input  logic [5:0]  cnt,
  input  logic [63:0] ord,
  input  logic [4:0]  btn,
  input  logic        mv_ready,
  output logic        mv_valid,
  output logic [1:0]  mv_dir,
  output logic [4:0]  idx,
  output logic        playing,
  output logic        done
);
`ifdef MOVE_SEQUENCER_REVERSE_EN
  localparam int BLO = 1;
`else
  localparam int BLO = 2;
`endif
  localparam int DW = $clog2(STEP_TICKS + 1);
  typedef enum logic [2:0] {S_IDLE, S_PAUSED, S_ISSUE, S_WAIT_ACK, S_DELAY, S_DONE} state_t;
  state_t state, state_d;
  logic [TICK_W-1:0] presc;
  logic tick, comp_q, rst_ev, unused;
  logic [4:BLO] flag, ev;
  logic [63:0] ord_q, ord_d;
  logic [5:0] cnt_q, cnt_d, cnt_sat;
  logic [4:0] idx_d;
  logic [1:0] mv_dir_d;
  logic [DW-1:0] dly, dly_d;
  logic done_d, playing_d, mv_valid_d, pend_rst, pend_rst_d, pend_play, pend_play_d;
`ifdef MOVE_SEQUENCER_REVERSE_EN
  logic rev, rev_d;
  logic [4:0] bidx;
  assign bidx = (done ? cnt_q[4:0] : idx) - 5'd1;
`endif
  assign unused  = ^btn[BLO-1:0];
  assign tick    = presc == '0;
  assign ev      = {(5-BLO){tick}} & btn[4:BLO] & ~flag;
  assign cnt_sat = cnt > 6'd32 ? 6'd32 : cnt;
  assign rst_ev  = ev[2] | (tick & pend_rst);
  always_comb begin
    state_d     = state;
    ord_d       = ord_q;
    cnt_d       = cnt_q;
    idx_d       = idx;
    done_d      = done;
    playing_d   = playing;
    mv_valid_d  = mv_valid;
    mv_dir_d    = mv_dir;
    dly_d       = dly;
    pend_rst_d  = pend_rst;
    pend_play_d = pend_play;
`ifdef MOVE_SEQUENCER_REVERSE_EN
    rev_d       = rev;
`endif
    if (state != S_IDLE && !comp) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      done_d      = 1'b0;
      playing_d   = 1'b0;
      mv_valid_d  = 1'b0;
      pend_rst_d  = 1'b0;
      pend_play_d = 1'b0;
`ifdef MOVE_SEQUENCER_REVERSE_EN
      rev_d       = 1'b0;
`endif
    end else if (rst_ev && (state == S_PAUSED || state == S_DELAY || state == S_DONE)) begin
      state_d    = cnt_q == '0 ? S_DONE : S_PAUSED;
      idx_d      = '0;
      done_d     = cnt_q == '0;
      playing_d  = 1'b0;
      pend_rst_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (comp && !comp_q) begin
          ord_d   = ord;
          cnt_d   = cnt_sat;
          idx_d   = '0;
          done_d  = cnt_sat == '0;
          state_d = cnt_sat == '0 ? S_DONE : S_PAUSED;
        end
        S_PAUSED: begin
          if (ev[4]) begin
            playing_d = 1'b1;
            state_d   = S_ISSUE;
          end else if (ev[3]) state_d = S_ISSUE;
`ifdef MOVE_SEQUENCER_REVERSE_EN
          else if (ev[1] && idx != '0) begin
            rev_d   = 1'b1;
            state_d = S_ISSUE;
          end
`endif
        end
        S_ISSUE: begin
`ifdef MOVE_SEQUENCER_REVERSE_EN
          mv_dir_d = rev ? ord_q[{bidx, 1'b0} +: 2] ^ 2'b01 : ord_q[{idx, 1'b0} +: 2];
`else
          mv_dir_d = ord_q[{idx, 1'b0} +: 2];
`endif
          mv_valid_d  = 1'b1;
          pend_rst_d  = pend_rst | ev[2];
          pend_play_d = pend_play ^ ev[4];
          state_d     = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // presses during the handshake are held until it completes
          pend_rst_d  = pend_rst | ev[2];
          pend_play_d = pend_play ^ ev[4];
          if (mv_ready) begin
            mv_valid_d  = 1'b0;
            pend_play_d = 1'b0;
`ifdef MOVE_SEQUENCER_REVERSE_EN
            if (rev) begin
              idx_d   = bidx;
              done_d  = 1'b0;
              rev_d   = 1'b0;
              state_d = S_PAUSED;
            end else
`endif
            if ({1'b0, idx} + 6'd1 == cnt_q) begin
              idx_d     = '0;
              done_d    = 1'b1;
              playing_d = 1'b0;
              state_d   = S_DONE;
            end else begin
              idx_d     = idx + 5'd1;
              playing_d = playing ^ pend_play ^ ev[4];
              state_d   = playing_d ? S_DELAY : S_PAUSED;
              dly_d     = DW'(STEP_TICKS);
            end
          end
        end
        S_DELAY: begin
          if (ev[4]) begin
            playing_d = 1'b0;
            state_d   = S_PAUSED;
          end else if (tick) begin
            dly_d = dly - 1'b1;
            if (dly == DW'(1)) state_d = S_ISSUE;
          end
        end
`ifdef MOVE_SEQUENCER_REVERSE_EN
        S_DONE: if (ev[1] && cnt_q != '0) begin
          rev_d   = 1'b1;
          state_d = S_ISSUE;
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      flag      <= '0;
      comp_q    <= 1'b0;
      ord_q     <= '0;
      cnt_q     <= '0;
      idx       <= '0;
      done      <= 1'b0;
      playing   <= 1'b0;
      mv_valid  <= 1'b0;
      mv_dir    <= '0;
      dly       <= '0;
      pend_rst  <= 1'b0;
      pend_play <= 1'b0;
`ifdef MOVE_SEQUENCER_REVERSE_EN
      rev       <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      presc     <= presc + 1'b1;
      if (tick) flag <= btn[4:BLO];
      comp_q    <= comp;
      ord_q     <= ord_d;
      cnt_q     <= cnt_d;
      idx       <= idx_d;
      done      <= done_d;
      playing   <= playing_d;
      mv_valid  <= mv_valid_d;
      mv_dir    <= mv_dir_d;
      dly       <= dly_d;
      pend_rst  <= pend_rst_d;
      pend_play <= pend_play_d;
`ifdef MOVE_SEQUENCER_REVERSE_EN
      rev       <= rev_d;
`endif
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed and randomized checks of move_sequencer against a move-list model.
module tb_move_sequencer;
  localparam int TICK_W = 2, STEP_TICKS = 1, TP = 1 << TICK_W;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  logic clk = 1'b0, rst = 1'b1, comp = 1'b0, mv_ready = 1'b0;
  logic [5:0] cnt = '0;
  logic [63:0] ord = '0;
  logic [4:0] btn = '0;
  logic mv_valid, playing, done;
  logic [1:0] mv_dir;
  logic [4:0] idx;
  int errors = 0, checks = 0, cyc = 0;
  logic [1:0] hs_dir[$];
  logic [4:0] hs_idx[$];
  int hs_cyc[$];
  logic pv = 1'b0, pr = 1'b0;
  logic [1:0] pd = '0;
  always #5 clk = ~clk;
  move_sequencer #(.TICK_W(TICK_W), .STEP_TICKS(STEP_TICKS)) dut (
    .clk(clk), .rst(rst), .comp(comp), .cnt(cnt), .ord(ord), .btn(btn), .mv_ready(mv_ready),
    .mv_valid(mv_valid), .mv_dir(mv_dir), .idx(idx), .playing(playing), .done(done)
  );
  // handshake recorder and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && comp && pv && !pr) begin
      checks++;
      assert (mv_valid === 1'b1 && mv_dir === pd) else begin
        errors++;
        $error("FAIL hold_stable observed valid=%b dir=%0d expected valid=1 dir=%0d", mv_valid, mv_dir, pd);
      end
    end
    if (mv_valid === 1'b1 && mv_ready === 1'b1) begin
      hs_dir.push_back(mv_dir);
      hs_idx.push_back(idx);
      hs_cyc.push_back(cyc);
    end
    pv <= mv_valid;
    pr <= mv_ready;
    pd <= mv_dir;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [1:0] mv(logic [63:0] o, int i);
    logic [63:0] s;
    s = o >> (2 * i);
    return s[1:0];
  endfunction
  function automatic logic [31:0] hd(int i);
    return hs_dir.size() > i ? 32'(hs_dir[i]) : 'x;
  endfunction
  function automatic logic [31:0] hi(int i);
    return hs_idx.size() > i ? 32'(hs_idx[i]) : 'x;
  endfunction
  function automatic logic [31:0] hc(int i);
    return hs_cyc.size() > i ? 32'(hs_cyc[i]) : 'x;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clk1(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(int k);
    btn[k] = 1'b1;
    clk1(6);
    btn[k] = 1'b0;
    clk1(8);
  endtask
  task automatic wait_valid(string tag);
    int n = 0;
    while (mv_valid !== 1'b1 && n < 20) begin
      clk1(1);
      n++;
    end
    chk(tag, 32'(mv_valid), 1);
  endtask
  task automatic clear_hs();
    hs_dir.delete();
    hs_idx.delete();
    hs_cyc.delete();
  endtask
  task automatic load(logic [5:0] c, logic [63:0] o);
    comp = 1'b0;
    clk1(2);
    ord = o;
    cnt = c;
    comp = 1'b1;
    clk1(3);
    clear_hs();
  endtask
  task automatic run_play(string tag, logic [5:0] c, logic [63:0] o, bit rnd);
    int n;
    n = c > 6'd32 ? 32 : int'(c);
    load(c, o);
    chk({tag, "_load_done"}, 32'(done), 0);
    chk({tag, "_load_idx"}, 32'(idx), 0);
    mv_ready = 1'b1;
    btn[4] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k == 6) begin
        btn[4] = 1'b0;
        if (n >= 3) chk({tag, "_playing"}, 32'(playing), 1);
      end
      if (rnd) mv_ready = 1'($urandom_range(0, 1));
      if (k >= 6 && done === 1'b1) break;
      clk1(1);
    end
    btn[4] = 1'b0;
    mv_ready = 1'b1;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_end_playing"}, 32'(playing), 0);
    chk({tag, "_end_idx"}, 32'(idx), 0);
    chk({tag, "_count"}, hs_dir.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_dir%0d", tag, i), hd(i), 32'(mv(o, i)));
      chk($sformatf("%s_idx%0d", tag, i), hi(i), 32'(i[4:0]));
      if (!rnd && i > 0) chk($sformatf("%s_gap%0d", tag, i), hc(i) - hc(i - 1), TP);
    end
  endtask
  initial begin
    logic [63:0] o;
    logic [5:0] c;
    logic [1:0] d0;
    clk1(3);
    rst = 1'b0;
    chk("rst_valid", 32'(mv_valid), 0);
    chk("rst_dir", 32'(mv_dir), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_done", 32'(done), 0);
    o = {$urandom, $urandom};
    o[5:0] = {RIGHT, LEFT, UP};
    run_play("plan1", 6'd3, o, 1'b0);
    press(2);
    chk("restart_done_idx", 32'(idx), 0);
    chk("restart_done_done", 32'(done), 0);
    for (int r = 0; r < 4; r++) begin
      c = 6'($urandom_range(1, 40));
      o = {$urandom, $urandom};
      run_play($sformatf("rnd%0d", r), c, o, 1'b1);
    end
    run_play("sat", 6'd40, {$urandom, $urandom}, 1'b0);
    o = {$urandom, $urandom};
    load(6'd5, o);
    mv_ready = 1'b1;
    btn[3] = 1'b1;
    clk1(5 * TP);
    btn[3] = 1'b0;
    clk1(8);
    chk("held_count", hs_dir.size(), 1);
    chk("held_dir", hd(0), 32'(mv(o, 0)));
    chk("held_idx", 32'(idx), 1);
    btn[2] = 1'b1;
    btn[3] = 1'b1;
    clk1(6);
    btn = '0;
    clk1(8);
    chk("rs_idx", 32'(idx), 0);
    chk("rs_count", hs_dir.size(), 1);
    chk("rs_valid", 32'(mv_valid), 0);
    mv_ready = 1'b0;
    btn[3] = 1'b1;
    wait_valid("bp_valid");
    btn[3] = 1'b0;
    d0 = mv(o, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 32'(mv_valid), 1);
      chk("bp_hold_dir", 32'(mv_dir), 32'(d0));
      chk("bp_hold_idx", 32'(idx), 0);
      clk1(1);
    end
    mv_ready = 1'b1;
    clk1(1);
    chk("bp_after_valid", 32'(mv_valid), 0);
    chk("bp_after_idx", 32'(idx), 1);
    chk("bp_after_dir", hd(1), 32'(d0));
    clk1(12);
    chk("bp_paused_count", hs_dir.size(), 2);
    chk("bp_paused_valid", 32'(mv_valid), 0);
    mv_ready = 1'b0;
    btn[3] = 1'b1;
    wait_valid("ab_valid");
    btn[3] = 1'b0;
    chk("ab_pre_idx", 32'(idx), 1);
    comp = 1'b0;
    clk1(1);
    chk("ab_valid_low", 32'(mv_valid), 0);
    chk("ab_idx", 32'(idx), 0);
    chk("ab_playing", 32'(playing), 0);
    chk("ab_done", 32'(done), 0);
    clk1(4);
    chk("ab_idle_valid", 32'(mv_valid), 0);
    load(6'd0, {$urandom, $urandom});
    chk("zero_done", 32'(done), 1);
    chk("zero_idx", 32'(idx), 0);
    mv_ready = 1'b1;
    press(4);
    clk1(8);
    chk("zero_count", hs_dir.size(), 0);
    chk("zero_valid", 32'(mv_valid), 0);
    chk("zero_done_held", 32'(done), 1);
    chk("zero_playing", 32'(playing), 0);
`ifdef MOVE_SEQUENCER_REVERSE_EN
    o = {$urandom, $urandom};
    o[3:0] = {LEFT, UP};
    load(6'd4, o);
    mv_ready = 1'b1;
    press(3);
    press(3);
    chk("rv_pre_idx", 32'(idx), 2);
    press(1);
    chk("rv_count", hs_dir.size(), 3);
    chk("rv_dir", hd(2), 32'(RIGHT));
    chk("rv_idx", 32'(idx), 1);
    chk("rv_done", 32'(done), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
